// File: rtl/frame_filler_if.sv
// frame_filler_if: CPU fill-request handshake and memory write-port handshake
interface frame_filler_if;
    logic [23:0] filler_color;
    logic        filler_valid;
    logic        filler_ready;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [3:0]  mem_we;

    // Engine side: accepts fill requests, drives memory write beats
    modport master (
        input  filler_color, filler_valid, mem_ready,
        output filler_ready, mem_valid, mem_addr, mem_din, mem_we
    );

    // Environment side: CPU request source and memory arbiter
    modport slave (
        output filler_color, filler_valid, mem_ready,
        input  filler_ready, mem_valid, mem_addr, mem_din, mem_we
    );
endinterface

// File: rtl/frame_filler.sv
// frame_filler: writes one latched colour to every visible frame-buffer pixel, one word per beat
module frame_filler #(
    parameter logic [31:0] FB_BASE  = 32'h1080_0000,
    parameter int          H_PIXELS = 800,
    parameter int          V_PIXELS = 600,
    parameter int          ROW_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    frame_filler_if.master        bus,
    output logic                  busy
);
    typedef enum logic {IDLE, FILL} state_t;

    localparam logic [ROW_LOG2-1:0] X_LAST = ROW_LOG2'(H_PIXELS - 1);
    localparam logic [ROW_LOG2-1:0] X_ONE  = ROW_LOG2'(1);
    localparam logic [9:0]          Y_LAST = 10'(V_PIXELS - 1);

    state_t              state_q, state_d;
    logic [ROW_LOG2-1:0] x_q, x_d;
    logic [9:0]          y_q, y_d;
    logic [23:0]         color_q, color_d;

    // Next-state: accept a request in IDLE, walk pixels row-major on each transferred beat
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        color_d = color_q;
        case (state_q)
            IDLE: if (bus.filler_valid) begin
                color_d = bus.filler_color;
                x_d     = '0;
                y_d     = '0;
                state_d = FILL;
            end
            FILL: if (bus.mem_ready) begin
                if (x_q == X_LAST) begin
                    x_d     = '0;
                    y_d     = y_q + 10'd1;
                    state_d = (y_q == Y_LAST) ? IDLE : FILL;
                end else begin
                    x_d = x_q + X_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pixel counters and colour register; reset abandons any fill in progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
        end
    end

    // Outputs depend only on registers, so a held beat stays stable while mem_ready is low
    assign bus.filler_ready = (state_q == IDLE);
    assign bus.mem_valid    = (state_q == FILL);
    assign busy             = (state_q == FILL);
    assign bus.mem_we       = (state_q == FILL) ? 4'hF : 4'h0;
    assign bus.mem_din      = {8'h00, color_q};
    assign bus.mem_addr     = FB_BASE + (((32'(y_q) << ROW_LOG2) + 32'(x_q)) << 2);
endmodule

// File: tb/tb_frame_filler.sv
// tb_frame_filler: random fills on two engines (row strides 4 and 8) checked against a pixel-index model
module tb_frame_filler;
    localparam logic [31:0] BASE = 32'h1080_0000;
    localparam int H = 4;
    localparam int V = 3;
    localparam int NPIX = H * V;

    logic clk = 1'b0;
    logic rst;
    logic busy_a, busy_b;
    int checks = 0;
    int errors = 0;

    frame_filler_if bus_a ();
    frame_filler_if bus_b ();

    assign bus_b.filler_color = bus_a.filler_color;
    assign bus_b.filler_valid = bus_a.filler_valid;
    assign bus_b.mem_ready    = bus_a.mem_ready;

    frame_filler #(.FB_BASE(BASE), .H_PIXELS(H), .V_PIXELS(V), .ROW_LOG2(2)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .busy(busy_a)
    );
    frame_filler #(.FB_BASE(BASE), .H_PIXELS(H), .V_PIXELS(V), .ROW_LOG2(3)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input int k, input int r);
        return BASE + 32'(((k / H) * (1 << r) + (k % H)) * 4);
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_ready_a"}, 32'(bus_a.filler_ready), 1);
        check({tag, "_ready_b"}, 32'(bus_b.filler_ready), 1);
        check({tag, "_valid_a"}, 32'(bus_a.mem_valid), 0);
        check({tag, "_valid_b"}, 32'(bus_b.mem_valid), 0);
        check({tag, "_we_a"}, 32'(bus_a.mem_we), 0);
        check({tag, "_busy_a"}, 32'(busy_a), 0);
        check({tag, "_busy_b"}, 32'(busy_b), 0);
    endtask

    task automatic start(input logic [23:0] col);
        bus_a.filler_color = col;
        bus_a.filler_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_a.filler_valid = 1'b0;
        bus_a.filler_color = 24'($urandom);
    endtask

    task automatic stream(input logic [23:0] col, input int mode, input bit mid, input logic [23:0] mid_col);
        int k = 0;
        int cyc = 0;
        bit xfer;
        while (k < NPIX && cyc < 400) begin
            bus_a.mem_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            if (mid && k == 4) begin
                bus_a.filler_valid = 1'b1;
                bus_a.filler_color = mid_col;
            end
            @(negedge clk);
            check("valid_a", 32'(bus_a.mem_valid), 1);
            check("valid_b", 32'(bus_b.mem_valid), 1);
            check("ready_a", 32'(bus_a.filler_ready), 0);
            check("busy_a", 32'(busy_a), 1);
            check("addr_a", bus_a.mem_addr, exp_addr(k, 2));
            check("addr_b", bus_b.mem_addr, exp_addr(k, 3));
            check("din_a", bus_a.mem_din, {8'h00, col});
            check("din_b", bus_b.mem_din, {8'h00, col});
            check("we_a", 32'(bus_a.mem_we), 32'hF);
            xfer = bus_a.mem_ready;
            @(posedge clk);
            #1;
            if (xfer) k++;
            cyc++;
        end
        check("beats", k, NPIX);
        @(negedge clk);
        check_idle("end");
    endtask

    initial begin
        logic [23:0] col;
        rst = 1'b0;
        bus_a.filler_valid = 1'b0;
        bus_a.filler_color = '0;
        bus_a.mem_ready = 1'b0;
        #2;
        check_idle("reset");
        check("reset_addr", bus_a.mem_addr, BASE);
        check("reset_din", bus_a.mem_din, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (100) begin
            bus_a.mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_idle("quiet");
        end
        @(posedge clk);
        #1;
        start(24'hABCDEF);
        stream(24'hABCDEF, 0, 1'b0, '0);
        repeat (3) begin
            @(negedge clk);
            check_idle("after");
        end
        @(posedge clk);
        #1;
        start(24'h5A5A5A);
        stream(24'h5A5A5A, 1, 1'b0, '0);
        @(posedge clk);
        #1;
        start(24'hAABBCC);
        stream(24'hAABBCC, 0, 1'b1, 24'h112233);
        @(posedge clk);
        #1;
        bus_a.filler_valid = 1'b0;
        stream(24'h112233, 0, 1'b0, '0);
        @(posedge clk);
        #1;
        start(24'h0F1E2D);
        bus_a.mem_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_addr_a", bus_a.mem_addr, exp_addr(5, 2));
        rst = 1'b0;
        #1;
        check_idle("async_rst");
        check("async_rst_addr", bus_a.mem_addr, BASE);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check_idle("post_rst");
        end
        @(posedge clk);
        #1;
        col = 24'($urandom);
        start(col);
        stream(col, 0, 1'b0, '0);
        repeat (4) begin
            @(posedge clk);
            #1;
            col = 24'($urandom);
            start(col);
            stream(col, 2, 1'b0, '0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
